// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared defaults and the writeback-source encoding for the register-file
// write-port arbiter.
package regfile_wb_arbiter_pkg;

   localparam int DEF_NUMBER_OF_REGISTERS = 32;
   localparam int DEF_DATA_WIDTH          = 32;
   localparam int DEF_AW                  = $clog2(DEF_NUMBER_OF_REGISTERS);
   localparam int DEF_MAX_OUTSTANDING     = 4;

   typedef enum logic [1:0] {
      WB_NONE,
      WB_PIPE,
      WB_MDU_DIRECT,
      WB_MDU_BUF
   } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Tracks registers awaiting MUL/DIV results and the number of long operations
// in flight, and derives the issue stall from both.
module regfile_scoreboard
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NUMBER_OF_REGISTERS = DEF_NUMBER_OF_REGISTERS,
   parameter int MAX_OUTSTANDING     = DEF_MAX_OUTSTANDING,
   parameter int AW                  = $clog2(NUMBER_OF_REGISTERS)
)(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_issueValid,
   input  logic                           i_issueLong,
   input  logic [AW-1:0]                  i_rs1,
   input  logic [AW-1:0]                  i_rs2,
   input  logic [AW-1:0]                  i_rd,
   input  logic                           i_mduSel,
   input  logic                           i_clrValid,
   input  logic [AW-1:0]                  i_clrAddr,
   output logic                           o_stall,
   output logic [NUMBER_OF_REGISTERS-1:0] o_busy
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   logic [NUMBER_OF_REGISTERS-1:0] r_busy;
   logic [NUMBER_OF_REGISTERS-1:0] w_busyNext;
   logic [CW-1:0]                  r_count;
   logic                           w_longAccept;
   logic                           w_countFull;

   assign w_countFull  = (r_count == CW'(MAX_OUTSTANDING));
   assign o_stall      = i_issueValid &&
                         (r_busy[i_rs1] || r_busy[i_rs2] || r_busy[i_rd] ||
                          (i_issueLong && w_countFull));
   assign w_longAccept = i_issueValid && i_issueLong && !o_stall;
   assign o_busy       = r_busy;

   // A clear and a set never target the same register in one cycle, because a
   // busy destination stalls the issue; bit 0 is pinned low regardless.
   always_comb begin
      w_busyNext = r_busy;
      if (i_clrValid) begin
         w_busyNext[i_clrAddr] = 1'b0;
      end
      if (w_longAccept && (i_rd != '0)) begin
         w_busyNext[i_rd] = 1'b1;
      end
      w_busyNext[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy  <= '0;
         r_count <= '0;
      end else begin
         r_busy <= w_busyNext;
         unique case ({w_longAccept, i_mduSel})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the in-order pipeline
// and the MUL/DIV unit, with a one-entry buffer for displaced MUL/DIV results.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int NUMBER_OF_REGISTERS = DEF_NUMBER_OF_REGISTERS,
   parameter int DATA_WIDTH          = DEF_DATA_WIDTH,
   parameter int MAX_OUTSTANDING     = DEF_MAX_OUTSTANDING,
   parameter int AW                  = $clog2(NUMBER_OF_REGISTERS)
)(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           issue_valid_i,
   input  logic                           issue_long_i,
   input  logic [AW-1:0]                  issue_rs1_i,
   input  logic [AW-1:0]                  issue_rs2_i,
   input  logic [AW-1:0]                  issue_rd_i,
   output logic                           issue_stall_o,
   input  logic                           wb_valid_i,
   input  logic [AW-1:0]                  wb_rd_i,
   input  logic [DATA_WIDTH-1:0]          wb_data_i,
   input  logic                           mdu_valid_i,
   input  logic [AW-1:0]                  mdu_rd_i,
   input  logic [DATA_WIDTH-1:0]          mdu_data_i,
   output logic                           mdu_ready_o,
   output logic                           rd_we_o,
   output logic [AW-1:0]                  rd_address_o,
   output logic [DATA_WIDTH-1:0]          rd_data_o,
   output logic [NUMBER_OF_REGISTERS-1:0] busy_o
);

   logic                  r_bufValid;
   logic [AW-1:0]         r_bufRd;
   logic [DATA_WIDTH-1:0] r_bufData;
   logic                  r_rdWe;
   logic [AW-1:0]         r_rdAddress;
   logic [DATA_WIDTH-1:0] r_rdData;
   logic                  r_wbIsMdu;

   wb_src_e               w_src;
   logic [AW-1:0]         w_selAddr;
   logic [DATA_WIDTH-1:0] w_selData;
   logic                  w_mduAccept;
   logic                  w_mduSel;
   logic                  w_clrValid;

   assign mdu_ready_o = !r_bufValid;
   assign w_mduAccept = mdu_valid_i && mdu_ready_o;
   assign w_mduSel    = (w_src == WB_MDU_DIRECT) || (w_src == WB_MDU_BUF);
   assign w_clrValid  = r_rdWe && r_wbIsMdu;

   // The pipeline cannot be back-pressured so it always wins; a parked result
   // drains before any new MUL/DIV result can be accepted.
   always_comb begin
      w_src     = WB_NONE;
      w_selAddr = '0;
      w_selData = '0;
      if (wb_valid_i) begin
         w_src     = WB_PIPE;
         w_selAddr = wb_rd_i;
         w_selData = wb_data_i;
      end else if (r_bufValid) begin
         w_src     = WB_MDU_BUF;
         w_selAddr = r_bufRd;
         w_selData = r_bufData;
      end else if (w_mduAccept) begin
         w_src     = WB_MDU_DIRECT;
         w_selAddr = mdu_rd_i;
         w_selData = mdu_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bufValid <= 1'b0;
         r_bufRd    <= '0;
         r_bufData  <= '0;
      end else if (w_src == WB_MDU_BUF) begin
         r_bufValid <= 1'b0;
      end else if (w_mduAccept && wb_valid_i) begin
         r_bufValid <= 1'b1;
         r_bufRd    <= mdu_rd_i;
         r_bufData  <= mdu_data_i;
      end
   end

   // Writes to x0 are suppressed here, but still count as MUL/DIV completions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdWe      <= 1'b0;
         r_rdAddress <= '0;
         r_rdData    <= '0;
         r_wbIsMdu   <= 1'b0;
      end else begin
         r_rdWe    <= (w_src != WB_NONE) && (w_selAddr != '0);
         r_wbIsMdu <= w_mduSel;
         if (w_src != WB_NONE) begin
            r_rdAddress <= w_selAddr;
            r_rdData    <= w_selData;
         end
      end
   end

   assign rd_we_o      = r_rdWe;
   assign rd_address_o = r_rdAddress;
   assign rd_data_o    = r_rdData;

   regfile_scoreboard #(
      .NUMBER_OF_REGISTERS (NUMBER_OF_REGISTERS),
      .MAX_OUTSTANDING     (MAX_OUTSTANDING),
      .AW                  (AW)
   ) u_scoreboard (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_issueValid (issue_valid_i),
      .i_issueLong  (issue_long_i),
      .i_rs1        (issue_rs1_i),
      .i_rs2        (issue_rs2_i),
      .i_rd         (issue_rd_i),
      .i_mduSel     (w_mduSel),
      .i_clrValid   (w_clrValid),
      .i_clrAddr    (r_rdAddress),
      .o_stall      (issue_stall_o),
      .o_busy       (busy_o)
   );

endmodule
